// File: rtl/morse_encoder.sv
// Morse keyer: sends one character (A..Z, 0..9) as timed key_out marks paced by tick.
// Optional word-space (code 63) support is enabled by defining MORSE_ENC_WORDGAP_EN.
module morse_encoder #(
  parameter int LGAP_UNITS = 3
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [5:0] char_code,
  output logic       key_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MARK  = 3'd1,
    SPACE = 3'd2,
`ifdef MORSE_ENC_WORDGAP_EN
    WGAP  = 3'd4,
`endif
    LGAP  = 3'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pat;
  } lut_t;

  localparam logic [2:0] LGAP_LAST = 3'(LGAP_UNITS - 1);
  localparam logic [2:0] WGAP_LAST = 3'd6;

  // Pattern is returned left-aligned: bit 4 is the first symbol, 1 = dash.
  function automatic lut_t lookup(input logic [5:0] code);
    lut_t       r;
    logic [4:0] raw;
    r.valid = 1'b1;
    r.len   = 3'd0;
    raw     = 5'b00000;
    case (code)
      6'd0:  {r.len, raw} = {3'd2, 5'b00001};
      6'd1:  {r.len, raw} = {3'd4, 5'b01000};
      6'd2:  {r.len, raw} = {3'd4, 5'b01010};
      6'd3:  {r.len, raw} = {3'd3, 5'b00100};
      6'd4:  {r.len, raw} = {3'd1, 5'b00000};
      6'd5:  {r.len, raw} = {3'd4, 5'b00010};
      6'd6:  {r.len, raw} = {3'd3, 5'b00110};
      6'd7:  {r.len, raw} = {3'd4, 5'b00000};
      6'd8:  {r.len, raw} = {3'd2, 5'b00000};
      6'd9:  {r.len, raw} = {3'd4, 5'b00111};
      6'd10: {r.len, raw} = {3'd3, 5'b00101};
      6'd11: {r.len, raw} = {3'd4, 5'b00100};
      6'd12: {r.len, raw} = {3'd2, 5'b00011};
      6'd13: {r.len, raw} = {3'd2, 5'b00010};
      6'd14: {r.len, raw} = {3'd3, 5'b00111};
      6'd15: {r.len, raw} = {3'd4, 5'b00110};
      6'd16: {r.len, raw} = {3'd4, 5'b01101};
      6'd17: {r.len, raw} = {3'd3, 5'b00010};
      6'd18: {r.len, raw} = {3'd3, 5'b00000};
      6'd19: {r.len, raw} = {3'd1, 5'b00001};
      6'd20: {r.len, raw} = {3'd3, 5'b00001};
      6'd21: {r.len, raw} = {3'd4, 5'b00001};
      6'd22: {r.len, raw} = {3'd3, 5'b00011};
      6'd23: {r.len, raw} = {3'd4, 5'b01001};
      6'd24: {r.len, raw} = {3'd4, 5'b01011};
      6'd25: {r.len, raw} = {3'd4, 5'b01100};
      6'd26: {r.len, raw} = {3'd5, 5'b11111};
      6'd27: {r.len, raw} = {3'd5, 5'b01111};
      6'd28: {r.len, raw} = {3'd5, 5'b00111};
      6'd29: {r.len, raw} = {3'd5, 5'b00011};
      6'd30: {r.len, raw} = {3'd5, 5'b00001};
      6'd31: {r.len, raw} = {3'd5, 5'b00000};
      6'd32: {r.len, raw} = {3'd5, 5'b10000};
      6'd33: {r.len, raw} = {3'd5, 5'b11000};
      6'd34: {r.len, raw} = {3'd5, 5'b11100};
      6'd35: {r.len, raw} = {3'd5, 5'b11110};
      default: r.valid = 1'b0;
    endcase
    r.pat = raw << (3'd5 - r.len);
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] pat_q, pat_d;
  logic [2:0] rem_q, rem_d;
  logic       key_q, key_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  lut_t       lk;
  logic [2:0] mark_last;

  always_comb begin
    lk        = lookup(char_code);
    mark_last = pat_q[4] ? 3'd2 : 3'd0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    rem_d     = rem_q;
    key_d     = key_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        key_d  = 1'b0;
        busy_d = 1'b0;
        // A tick on the accepting edge is deliberately not counted.
        if (start) begin
          if (lk.valid) begin
            state_d = MARK;
            pat_d   = lk.pat;
            rem_d   = lk.len;
            cnt_d   = 3'd0;
            key_d   = 1'b1;
            busy_d  = 1'b1;
`ifdef MORSE_ENC_WORDGAP_EN
          end else if (char_code == 6'd63) begin
            state_d = WGAP;
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MARK: begin
        if (tick) begin
          if (cnt_q == mark_last) begin
            cnt_d   = 3'd0;
            key_d   = 1'b0;
            state_d = (rem_q > 3'd1) ? SPACE : LGAP;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      SPACE: begin
        if (tick) begin
          state_d = MARK;
          key_d   = 1'b1;
          pat_d   = pat_q << 1;
          rem_d   = rem_q - 3'd1;
        end
      end
      LGAP: begin
        if (tick) begin
          if (cnt_q == LGAP_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = 3'd0;
            pat_d   = 5'd0;
            rem_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
`ifdef MORSE_ENC_WORDGAP_EN
      WGAP: begin
        if (tick) begin
          if (cnt_q == WGAP_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
        key_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      pat_q   <= 5'd0;
      rem_q   <= 3'd0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign key_out   = key_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign state_dbg = state_q;

`ifndef MORSE_ENC_WORDGAP_EN
  logic unused_wgap;
  assign unused_wgap = ^WGAP_LAST;
`endif

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder: table of characters with expected key_out
// waveforms in tick units (tick every 4 cycles), plus hand-written corner sequences.
module tb_morse_encoder;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [5:0] char_code = 6'd0;
  logic       key_out, busy, done, err;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;

  morse_encoder #(.LGAP_UNITS(3)) dut (
    .CLK(CLK), .reset(reset), .tick(tick), .start(start), .char_code(char_code),
    .key_out(key_out), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [5:0]  code;
    logic [31:0] wave;   // key_out per unit, first unit in bit units-1
    int          units;
    bit          is_err;
    bit          tick0;  // tick asserted on the accepting edge
  } vec_t;

  vec_t vecs[12];

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plays already-accepted character: each unit is 3 quiet cycles plus one tick cycle.
  task automatic play(input logic [31:0] wave, input int units, input string nm);
    for (int u = 0; u < units; u++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s_key_u%0d", nm, u), {31'd0, key_out}, {31'd0, wave[units-1-u]});
        chk($sformatf("%s_busy_u%0d", nm, u), {31'd0, busy}, 32'd1);
        chk($sformatf("%s_done_u%0d", nm, u), {31'd0, done}, 32'd0);
        tick = (c == 3);
        cyc();
        tick = 1'b0;
      end
    end
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd1);
    chk({nm, "_busy_fall"}, {31'd0, busy}, 32'd0);
    chk({nm, "_key_end"}, {31'd0, key_out}, 32'd0);
    chk({nm, "_err_end"}, {31'd0, err}, 32'd0);
  endtask

  task automatic run_char(input vec_t v);
    start = 1'b1;
    char_code = v.code;
    tick = v.tick0;
    cyc();
    start = 1'b0;
    tick = 1'b0;
    char_code = 6'd40;
    if (v.is_err) begin
      chk({v.name, "_err_pulse"}, {31'd0, err}, 32'd1);
      chk({v.name, "_err_busy"}, {31'd0, busy}, 32'd0);
      chk({v.name, "_err_key"}, {31'd0, key_out}, 32'd0);
      chk({v.name, "_err_done"}, {31'd0, done}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        tick = (i % 4 == 3);
        cyc();
        chk({v.name, "_err_clear"}, {31'd0, err}, 32'd0);
        chk({v.name, "_err_busy_after"}, {31'd0, busy}, 32'd0);
        chk({v.name, "_err_key_after"}, {31'd0, key_out}, 32'd0);
      end
      tick = 1'b0;
    end else begin
      play(v.wave, v.units, v.name);
      cyc();
      chk({v.name, "_done_once"}, {31'd0, done}, 32'd0);
      chk({v.name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{"E",      6'd4,  32'b1000, 4, 1'b0, 1'b0};
    vecs[1]  = '{"E_tick0",6'd4,  32'b1000, 4, 1'b0, 1'b1};
    vecs[2]  = '{"A",      6'd0,  32'b10111000, 8, 1'b0, 1'b0};
    vecs[3]  = '{"T",      6'd19, 32'b111000, 6, 1'b0, 1'b0};
    vecs[4]  = '{"R",      6'd17, 32'b1011101000, 10, 1'b0, 1'b0};
    vecs[5]  = '{"Z",      6'd25, 32'b11101110101000, 14, 1'b0, 1'b0};
    vecs[6]  = '{"d5",     6'd31, 32'b101010101000, 12, 1'b0, 1'b1};
    vecs[7]  = '{"d0",     6'd26, 32'b1110111011101110111000, 22, 1'b0, 1'b0};
    vecs[8]  = '{"c40",    6'd40, 32'd0, 0, 1'b1, 1'b0};
    vecs[9]  = '{"c36",    6'd36, 32'd0, 0, 1'b1, 1'b0};
`ifdef MORSE_ENC_WORDGAP_EN
    vecs[10] = '{"c63_wgap", 6'd63, 32'd0, 7, 1'b0, 1'b0};
`else
    vecs[10] = '{"c63_err",  6'd63, 32'd0, 0, 1'b1, 1'b0};
`endif
    vecs[11] = '{"c62",    6'd62, 32'd0, 0, 1'b1, 1'b0};

    // Reset overrides start and tick.
    reset = 1'b1;
    start = 1'b1;
    char_code = 6'd4;
    tick = 1'b1;
    cyc();
    cyc();
    chk("rst_key", {31'd0, key_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick = 1'b0;
    cyc();
    chk("rst_idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 12; i++) run_char(vecs[i]);

    // Start held: R then T back to back, second accepted in the done cycle.
    start = 1'b1;
    char_code = 6'd17;
    cyc();
    char_code = 6'd19;
    play(32'b1011101000, 10, "b2b_R");
    cyc();
    chk("b2b_T_key_start", {31'd0, key_out}, 32'd1);
    chk("b2b_T_busy_start", {31'd0, busy}, 32'd1);
    chk("b2b_T_done_low", {31'd0, done}, 32'd0);
    start = 1'b0;
    play(32'b111000, 6, "b2b_T");
    cyc();
    chk("b2b_done_once", {31'd0, done}, 32'd0);

    // Reset during the second symbol (first dash) of J aborts with no done.
    start = 1'b1;
    char_code = 6'd9;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4 || c >= 8) chk("j_mark_key", {31'd0, key_out}, 32'd1);
      else chk("j_space_key", {31'd0, key_out}, 32'd0);
      tick = (c % 4 == 3);
      cyc();
      tick = 1'b0;
    end
    chk("j_dash_key", {31'd0, key_out}, 32'd1);
    reset = 1'b1;
    start = 1'b1;
    tick = 1'b1;
    cyc();
    chk("j_rst_key", {31'd0, key_out}, 32'd0);
    chk("j_rst_busy", {31'd0, busy}, 32'd0);
    chk("j_rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    tick = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick = (i % 4 == 3);
      cyc();
      chk("j_after_done", {31'd0, done}, 32'd0);
      chk("j_after_busy", {31'd0, busy}, 32'd0);
      chk("j_after_key", {31'd0, key_out}, 32'd0);
    end
    tick = 1'b0;

    run_char(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
